// File: rtl/serial_pattern_detector_pkg.sv
// ---------------------------------------------------------------------------
// serial_pattern_detector_pkg
//   Shared types and helpers for the serial pattern detector.
//   - state_e        : window FSM encoding (FILL / HUNT)
//   - fill_cnt_width : bits needed to count 0..PAT_LEN received samples
// ---------------------------------------------------------------------------
package serial_pattern_detector_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HUNT = 1'b1
  } state_e;

  // fill_cnt must reach PAT_LEN itself, hence PAT_LEN+1 distinct values.
  function automatic int fill_cnt_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/serial_pattern_detector_if.sv
// ---------------------------------------------------------------------------
// serial_pattern_detector_if
//   Bundles the serial input stream and the detector status outputs.
//   master : stream source / status observer (drives din_valid, din, clear)
//   slave  : detector (drives match, match_count, window, armed)
//   Parameters PAT_LEN and CNT_W must match the detector instance.
// ---------------------------------------------------------------------------
interface serial_pattern_detector_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 4
);

  logic               din_valid;
  logic               din;
  logic               clear;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic [PAT_LEN-1:0] window;
  logic               armed;

  modport master (
    output din_valid, din, clear,
    input  match, match_count, window, armed
  );

  modport slave (
    input  din_valid, din, clear,
    output match, match_count, window, armed
  );

endinterface

// File: rtl/serial_pattern_detector_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter: holds at all-ones instead of wrapping.
//   Ports:
//     clk    in  1  rising-edge clock
//     reset  in  1  synchronous active-high reset (highest priority)
//     clr    in  1  synchronous clear (beats inc)
//     inc    in  1  count up by one when not saturated
//     count  out W  current count (registered)
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/serial_pattern_detector.sv
// ---------------------------------------------------------------------------
// serial_pattern_detector
//   Watches a registered serial bit stream and flags a fixed PAT_LEN-bit
//   pattern (MSB = oldest bit). All outputs are registered.
//   Ports:
//     clk    in  1  rising-edge clock
//     reset  in  1  synchronous active-high reset (beats clear and din_valid)
//     bus    slave modport of serial_pattern_detector_if:
//              din_valid/din  sampled stream, clear = soft clear
//              match          one-cycle pulse after the completing sample
//              match_count    saturating match count
//              window         last PAT_LEN sampled bits, newest in LSB
//              armed          window holds PAT_LEN valid bits
//
//   state | meaning
//   FILL  | fewer than PAT_LEN valid bits collected since reset/clear/refill
//   HUNT  | window full; every sample is tested against PATTERN
// ---------------------------------------------------------------------------
module serial_pattern_detector
  import serial_pattern_detector_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  serial_pattern_detector_if.slave    bus
);

  localparam int FW = fill_cnt_width(PAT_LEN);

  state_e             state_q, state_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [PAT_LEN-1:0] win_q, win_d;
  logic               match_q, match_d;
  logic [PAT_LEN-1:0] win_shift;
  logic               completes;
  logic               hit;

  // Candidate window including the bit on the current edge; the compare
  // must see the new value, not the registered one.
  assign win_shift = {win_q[PAT_LEN-2:0], bus.din};

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    win_d     = win_q;
    match_d   = 1'b0;
    completes = 1'b0;
    hit       = 1'b0;

    if (bus.din_valid) begin
      win_d = win_shift;
      unique case (state_q)
        FILL: begin
          if (fill_q == FW'(PAT_LEN - 1)) begin
            completes = 1'b1;
            fill_d    = FW'(PAT_LEN);
            state_d   = HUNT;
          end else begin
            fill_d = fill_q + FW'(1);
          end
        end
        HUNT: begin
          completes = 1'b1;
        end
        default: begin
          state_d = FILL;
          fill_d  = '0;
        end
      endcase

      hit     = completes && (win_shift == PATTERN);
      match_d = hit;

      // Non-overlapping mode: bits already in the window are consumed by
      // this match, so the window must be refilled before the next test.
      if (hit && !OVERLAP) begin
        state_d = FILL;
        fill_d  = '0;
      end
    end

    if (bus.clear) begin
      state_d = FILL;
      fill_d  = '0;
      win_d   = '0;
      match_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      fill_q  <= '0;
      win_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      win_q   <= win_d;
      match_q <= match_d;
    end
  end

  // match_d is already forced low by clear; clr also dominates inside.
  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clear),
    .inc   (match_d),
    .count (bus.match_count)
  );

  assign bus.match  = match_q;
  assign bus.window = win_q;
  assign bus.armed  = (state_q == HUNT);

endmodule

// File: tb/tb_serial_pattern_detector.sv
// ---------------------------------------------------------------------------
// tb_serial_pattern_detector
//   Three detector instances share one stimulus stream:
//     u0 : OVERLAP=1, CNT_W=4
//     u1 : OVERLAP=0, CNT_W=4
//     u2 : OVERLAP=1, CNT_W=2
//   A behavioural reference predicts each instance's outputs; predictions
//   are queued when stimulus is driven and compared after the clock edge.
// ---------------------------------------------------------------------------
module tb_serial_pattern_detector;

  logic clk;
  logic reset;
  logic din_valid;
  logic din;
  logic clear;

  serial_pattern_detector_if #(.PAT_LEN(4), .CNT_W(4)) if0 ();
  serial_pattern_detector_if #(.PAT_LEN(4), .CNT_W(4)) if1 ();
  serial_pattern_detector_if #(.PAT_LEN(4), .CNT_W(2)) if2 ();

  assign if0.din_valid = din_valid;
  assign if0.din       = din;
  assign if0.clear     = clear;
  assign if1.din_valid = din_valid;
  assign if1.din       = din;
  assign if1.clear     = clear;
  assign if2.din_valid = din_valid;
  assign if2.din       = din;
  assign if2.clear     = clear;

  serial_pattern_detector #(
    .PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(4)
  ) u0 (.clk(clk), .reset(reset), .bus(if0));

  serial_pattern_detector #(
    .PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(4)
  ) u1 (.clk(clk), .reset(reset), .bus(if1));

  serial_pattern_detector #(
    .PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)
  ) u2 (.clk(clk), .reset(reset), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       m;
    int       cnt;
    bit [3:0] win;
    int       nbits;
  } mstate_t;

  typedef struct {
    logic       m;
    int         cnt;
    logic [3:0] win;
    logic       armed;
  } exp_t;

  mstate_t ms [3];
  bit      ovl  [3] = '{1'b1, 1'b0, 1'b1};
  int      cmax [3] = '{15, 15, 3};
  exp_t    q0 [$];
  exp_t    q1 [$];
  exp_t    q2 [$];

  int n_checks = 0;
  int n_errors = 0;
  int pulses [3] = '{0, 0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic mstate_t model_step(input mstate_t s, input bit rst, input bit clr,
                                         input bit v, input bit d, input bit ov, input int mx);
    mstate_t n;
    n   = s;
    n.m = 1'b0;
    if (rst || clr) begin
      n.nbits = 0;
      n.win   = 4'b0000;
      n.cnt   = 0;
      return n;
    end
    if (!v) return n;
    n.win   = {s.win[2:0], d};
    n.nbits = (s.nbits < 4) ? s.nbits + 1 : 4;
    if (n.nbits == 4 && n.win == 4'b1011) begin
      n.m = 1'b1;
      if (n.cnt < mx) n.cnt++;
      if (!ov) n.nbits = 0;
    end
    return n;
  endfunction

  task automatic cmp_inst(input int i, input exp_t e, input logic m, input logic [31:0] c,
                          input logic [3:0] w, input logic a);
    check($sformatf("u%0d.match", i), {31'b0, m}, {31'b0, e.m});
    check($sformatf("u%0d.match_count", i), c, e.cnt);
    check($sformatf("u%0d.window", i), {28'b0, w}, {28'b0, e.win});
    check($sformatf("u%0d.armed", i), {31'b0, a}, {31'b0, e.armed});
    if (m === 1'b1) pulses[i]++;
  endtask

  task automatic step(input bit rst, input bit clr, input bit v, input bit d);
    exp_t e;
    reset     = rst;
    clear     = clr;
    din_valid = v;
    din       = d;
    for (int i = 0; i < 3; i++) begin
      ms[i]   = model_step(ms[i], rst, clr, v, d, ovl[i], cmax[i]);
      e.m     = ms[i].m;
      e.cnt   = ms[i].cnt;
      e.win   = ms[i].win;
      e.armed = (ms[i].nbits == 4);
      case (i)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    @(posedge clk);
    #1;
    e = q0.pop_front();
    cmp_inst(0, e, if0.match, {28'b0, if0.match_count}, if0.window, if0.armed);
    e = q1.pop_front();
    cmp_inst(1, e, if1.match, {28'b0, if1.match_count}, if1.window, if1.armed);
    e = q2.pop_front();
    cmp_inst(2, e, if2.match, {30'b0, if2.match_count}, if2.window, if2.armed);
  endtask

  task automatic bits(input logic [15:0] stream, input int len);
    for (int k = len - 1; k >= 0; k--) step(1'b0, 1'b0, 1'b1, stream[k]);
  endtask

  task automatic clr_pulses();
    for (int i = 0; i < 3; i++) pulses[i] = 0;
  endtask

  logic [15:0] s7;
  logic [15:0] s13;
  logic [3:0]  w_hold;

  initial begin
    reset = 1'b1; clear = 1'b0; din_valid = 1'b0; din = 1'b0;
    for (int i = 0; i < 3; i++) ms[i] = '{m: 1'b0, cnt: 0, win: 4'b0, nbits: 0};
    s7  = 16'b0000_0000_0101_1011;   // 1,0,1,1,0,1,1
    s13 = 16'b0001_0110_1101_1011;   // 1,0,1,1,0,1,1,0,1,1,0,1,1

    // Reset held for two cycles; armed only rises after the 4th sample.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst.match", {31'b0, if0.match}, 32'd0);
    check("rst.count", {28'b0, if0.match_count}, 32'd0);
    check("rst.window", {28'b0, if0.window}, 32'd0);
    bits(16'b101, 3);
    check("armed_after3", {31'b0, if0.armed}, 32'd0);
    bits(16'b1, 1);
    check("armed_after4", {31'b0, if0.armed}, 32'd1);

    // Overlapping vs non-overlapping on 1,0,1,1,0,1,1.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    clr_pulses();
    bits(s7, 7);
    check("ovl.pulses", pulses[0], 32'd2);
    check("ovl.count", {28'b0, if0.match_count}, 32'd2);
    check("ovl.window", {28'b0, if0.window}, 32'b1011);
    check("novl.pulses", pulses[1], 32'd1);
    check("novl.count", {28'b0, if1.match_count}, 32'd1);
    check("novl.armed", {31'b0, if1.armed}, 32'd0);

    // Gaps of three invalid cycles between bits; window must hold.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    clr_pulses();
    for (int k = 3; k >= 0; k--) begin
      step(1'b0, 1'b0, 1'b1, s7[k + 3]);
      w_hold = if0.window;
      for (int g = 0; g < 3; g++) begin
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("gap.window_held", {28'b0, if0.window}, {28'b0, w_hold});
      end
    end
    check("gap.pulses", pulses[0], 32'd1);

    // Saturation on the 2-bit counter instance.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    clr_pulses();
    bits(s13, 13);
    check("sat.pulses", pulses[2], 32'd4);
    check("sat.count", {30'b0, if2.match_count}, 32'd3);
    check("wide.count", {28'b0, if0.match_count}, 32'd4);

    // Clear on the completing edge suppresses the match.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    clr_pulses();
    bits(16'b101, 3);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("clr.match", {31'b0, if0.match}, 32'd0);
    check("clr.count", {28'b0, if0.match_count}, 32'd0);
    check("clr.armed", {31'b0, if0.armed}, 32'd0);

    // Reset mid-stream discards the partial window.
    bits(16'b101, 3);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    clr_pulses();
    bits(16'b1011, 4);
    check("rst_mid.pulses", pulses[0], 32'd1);

    // Random stream with occasional clears and gaps.
    for (int k = 0; k < 200; k++) begin
      step(1'b0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
